// File: rtl/spi_cmd_pkg.sv
// ============================================================================
// Module      : spi_cmd_pkg
// Description : Shared frame geometry, register map and FSM state encoding
//               for the SPI command master.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package spi_cmd_pkg;

   localparam int FRAME_BITS = 24;
   localparam int ADDR_WIDTH = 3;
   localparam int DATA_WIDTH = 16;
   localparam int WORD_WIDTH = ADDR_WIDTH + DATA_WIDTH;

   localparam logic [ADDR_WIDTH-1:0] START_POINT   = 3'd1;
   localparam logic [ADDR_WIDTH-1:0] CHARGE_END    = 3'd2;
   localparam logic [ADDR_WIDTH-1:0] DISCHARGE_END = 3'd3;
   localparam logic [ADDR_WIDTH-1:0] END_DELAY     = 3'd4;
   localparam logic [ADDR_WIDTH-1:0] END_DISCHARGE = 3'd5;
   localparam logic [ADDR_WIDTH-1:0] CHANNEL_CTRL  = 3'd6;

   typedef enum logic [2:0] {
      IDLE   = 3'd0,
      LOAD   = 3'd1,
      BIT_LO = 3'd2,
      BIT_HI = 3'd3,
      HOLD   = 3'd4,
      GAP    = 3'd5
   } state_t;

   // Five leading zero bits pad the {addr,data} word up to the frame length.
   function automatic logic [FRAME_BITS-1:0] build_frame(input logic [WORD_WIDTH-1:0] word);
      return {{(FRAME_BITS-WORD_WIDTH){1'b0}}, word};
   endfunction

endpackage

`default_nettype wire

// File: rtl/cmd_fifo.sv
// ============================================================================
// Module      : cmd_fifo
// Description : Synchronous command FIFO with full/empty flags and
//               first-word fall-through read data.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module cmd_fifo #(
   parameter int DEPTH = 4,
   parameter int WIDTH = 19
) (
   input  logic             clock,
   input  logic             reset_n,
   input  logic             push_i,
   input  logic [WIDTH-1:0] wdata_i,
   input  logic             pop_i,
   output logic [WIDTH-1:0] rdata_o,
   output logic             full_o,
   output logic             empty_o
);

   localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam logic [AW:0]   C_DEPTH = (AW+1)'(DEPTH);
   localparam logic [AW-1:0] C_LAST  = AW'(DEPTH-1);

   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [AW-1:0]    wr_ptr_q;
   logic [AW-1:0]    rd_ptr_q;
   logic [AW:0]      count_q;
   logic             do_push;
   logic             do_pop;

   assign full_o  = (count_q == C_DEPTH);
   assign empty_o = (count_q == '0);
   // A full FIFO refuses the push even when a pop frees a slot this cycle.
   assign do_push = push_i && !full_o;
   assign do_pop  = pop_i && !empty_o;
   assign rdata_o = mem_q[rd_ptr_q];

   always_ff @(posedge clock) begin
      if (do_push) begin
         mem_q[wr_ptr_q] <= wdata_i;
      end
   end

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         if (do_push) begin
            wr_ptr_q <= (wr_ptr_q == C_LAST) ? '0 : wr_ptr_q + AW'(1);
         end
         if (do_pop) begin
            rd_ptr_q <= (rd_ptr_q == C_LAST) ? '0 : rd_ptr_q + AW'(1);
         end
         case ({do_push, do_pop})
            2'b10:   count_q <= count_q + (AW+1)'(1);
            2'b01:   count_q <= count_q - (AW+1)'(1);
            default: count_q <= count_q;
         endcase
      end
   end

endmodule

`default_nettype wire

// File: rtl/spi_cmd_master.sv
// ============================================================================
// Module      : spi_cmd_master
// Description : Queues {addr,data} command words and shifts each out as a
//               24-bit SPI frame (mode 0, MSB first) with registered outputs.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module spi_cmd_master
   import spi_cmd_pkg::*;
#(
   parameter int CLK_DIV    = 4,
   parameter int FIFO_DEPTH = 4
) (
   input  logic                  clock,
   input  logic                  reset_n,
   input  logic                  cmd_valid,
   input  logic [ADDR_WIDTH-1:0] cmd_addr,
   input  logic [DATA_WIDTH-1:0] cmd_data,
   output logic                  cmd_ready,
   output logic                  busy,
   output logic                  frame_done,
   output logic                  spi_cs,
   output logic                  spi_sck,
   output logic                  spi_sda
);

   localparam logic [7:0] C_HALF_LAST = 8'(CLK_DIV - 1);
   localparam logic [4:0] C_LAST_BIT  = 5'(FRAME_BITS - 1);

   state_t                  state_q, state_d;
   logic [FRAME_BITS-1:0]   shift_q, shift_d;
   logic [4:0]              bit_cnt_q, bit_cnt_d;
   logic [7:0]              half_cnt_q, half_cnt_d;
   logic                    cs_q, cs_d;
   logic                    sck_q, sck_d;
   logic                    sda_q, sda_d;
   logic                    done_q, done_d;

   logic                    fifo_pop;
   logic                    fifo_full;
   logic                    fifo_empty;
   logic [WORD_WIDTH-1:0]   fifo_rdata;
   logic [FRAME_BITS-1:0]   new_frame;
   logic                    half_last;

   cmd_fifo #(
      .DEPTH (FIFO_DEPTH),
      .WIDTH (WORD_WIDTH)
   ) u_fifo (
      .clock   (clock),
      .reset_n (reset_n),
      .push_i  (cmd_valid),
      .wdata_i ({cmd_addr, cmd_data}),
      .pop_i   (fifo_pop),
      .rdata_o (fifo_rdata),
      .full_o  (fifo_full),
      .empty_o (fifo_empty)
   );

   assign new_frame = build_frame(fifo_rdata);
   assign half_last = (half_cnt_q == C_HALF_LAST);

   // SPI pins are computed for the next state and registered, so each pin
   // lines up with state_q and never sees a combinational path from cmd_*.
   always_comb begin
      state_d    = state_q;
      shift_d    = shift_q;
      bit_cnt_d  = bit_cnt_q;
      half_cnt_d = half_cnt_q;
      cs_d       = cs_q;
      sck_d      = sck_q;
      sda_d      = sda_q;
      done_d     = 1'b0;
      fifo_pop   = 1'b0;

      case (state_q)
         IDLE: begin
            cs_d  = 1'b1;
            sck_d = 1'b0;
            sda_d = 1'b0;
            if (!fifo_empty) begin
               fifo_pop = 1'b1;
               shift_d  = new_frame;
               cs_d     = 1'b0;
               sda_d    = new_frame[FRAME_BITS-1];
               state_d  = LOAD;
            end
         end
         LOAD: begin
            bit_cnt_d  = '0;
            half_cnt_d = '0;
            state_d    = BIT_LO;
         end
         BIT_LO: begin
            if (half_last) begin
               half_cnt_d = '0;
               sck_d      = 1'b1;
               state_d    = BIT_HI;
            end else begin
               half_cnt_d = half_cnt_q + 8'd1;
            end
         end
         BIT_HI: begin
            if (half_last) begin
               // Falling edge: the only place sda may move mid-frame.
               half_cnt_d = '0;
               sck_d      = 1'b0;
               shift_d    = shift_q << 1;
               sda_d      = shift_q[FRAME_BITS-2];
               bit_cnt_d  = bit_cnt_q + 5'd1;
               state_d    = (bit_cnt_q == C_LAST_BIT) ? HOLD : BIT_LO;
            end else begin
               half_cnt_d = half_cnt_q + 8'd1;
            end
         end
         HOLD: begin
            if (half_last) begin
               half_cnt_d = '0;
               cs_d       = 1'b1;
               done_d     = 1'b1;
               state_d    = GAP;
            end else begin
               half_cnt_d = half_cnt_q + 8'd1;
            end
         end
         GAP: begin
            if (half_last) begin
               half_cnt_d = '0;
               state_d    = IDLE;
            end else begin
               half_cnt_d = half_cnt_q + 8'd1;
            end
         end
         default: begin
            cs_d    = 1'b1;
            sck_d   = 1'b0;
            sda_d   = 1'b0;
            state_d = IDLE;
         end
      endcase
   end

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         state_q    <= IDLE;
         shift_q    <= '0;
         bit_cnt_q  <= '0;
         half_cnt_q <= '0;
         cs_q       <= 1'b1;
         sck_q      <= 1'b0;
         sda_q      <= 1'b0;
         done_q     <= 1'b0;
      end else begin
         state_q    <= state_d;
         shift_q    <= shift_d;
         bit_cnt_q  <= bit_cnt_d;
         half_cnt_q <= half_cnt_d;
         cs_q       <= cs_d;
         sck_q      <= sck_d;
         sda_q      <= sda_d;
         done_q     <= done_d;
      end
   end

   assign cmd_ready  = !fifo_full;
   assign busy       = (state_q != IDLE) || !fifo_empty;
   assign frame_done = done_q;
   assign spi_cs     = cs_q;
   assign spi_sck    = sck_q;
   assign spi_sda    = sda_q;

endmodule

`default_nettype wire

// File: tb/tb_spi_cmd_master.sv
// ============================================================================
// Module      : tb_spi_cmd_master
// Description : Scoreboard bench: two masters (CLK_DIV=4 and CLK_DIV=1)
//               decoded by an SPI receiver model.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_spi_cmd_master;

   logic clock = 1'b0;
   always #5 clock = ~clock;

   logic [1:0]       rstn;
   logic [1:0]       valid;
   logic [1:0][2:0]  addr;
   logic [1:0][15:0] data;
   logic [1:0]       ready, busy, done, cs, sck, sda;

   int n_checks = 0;
   int n_pass   = 0;
   int sent [2] = '{0, 0};
   int last_stall;

   logic [23:0] expq0 [$];
   logic [23:0] expq1 [$];

   spi_cmd_master #(.CLK_DIV(4), .FIFO_DEPTH(4)) u_dut0 (
      .clock(clock), .reset_n(rstn[0]), .cmd_valid(valid[0]), .cmd_addr(addr[0]),
      .cmd_data(data[0]), .cmd_ready(ready[0]), .busy(busy[0]), .frame_done(done[0]),
      .spi_cs(cs[0]), .spi_sck(sck[0]), .spi_sda(sda[0]));

   spi_cmd_master #(.CLK_DIV(1), .FIFO_DEPTH(4)) u_dut1 (
      .clock(clock), .reset_n(rstn[1]), .cmd_valid(valid[1]), .cmd_addr(addr[1]),
      .cmd_data(data[1]), .cmd_ready(ready[1]), .busy(busy[1]), .frame_done(done[1]),
      .spi_cs(cs[1]), .spi_sck(sck[1]), .spi_sda(sda[1]));

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h", name, act, exp);
   endtask

   function automatic int div_of(input int k);
      return (k == 0) ? 4 : 1;
   endfunction

   function automatic int qsize(input int k);
      return (k == 0) ? expq0.size() : expq1.size();
   endfunction

   // ---------------- receiver / monitor ----------------
   logic [1:0]  p_cs  = 2'b11;
   logic [1:0]  p_sck = 2'b00;
   logic [1:0]  p_sda = 2'b00;
   logic [23:0] rx [2];
   int nbits [2] = '{0, 0};
   int lo_cnt [2] = '{0, 0};
   int hi_cnt [2] = '{100, 100};
   int since_rise [2] = '{0, 0};
   int done_cnt [2] = '{0, 0};
   int viol [2] = '{0, 0};
   logic [23:0] exp_frame;

   always @(negedge clock) begin
      for (int k = 0; k < 2; k++) begin
         if (done[k]) done_cnt[k]++;
         if (p_sck[k] && sck[k] && (sda[k] !== p_sda[k])) viol[k]++;
         since_rise[k]++;
         if (cs[k]) hi_cnt[k]++;
         if (!rstn[k]) begin
            nbits[k]  = 0;
            lo_cnt[k] = 0;
         end else begin
            if (p_cs[k] && !cs[k]) begin
               chk("cs_high_gap", 32'(hi_cnt[k] >= div_of(k) + 1), 1);
               rx[k]     = '0;
               nbits[k]  = 0;
               lo_cnt[k] = 0;
            end
            if (!cs[k]) lo_cnt[k]++;
            if (!p_sck[k] && sck[k] && !cs[k]) begin
               if (nbits[k] > 0) chk("sck_period", since_rise[k], 2 * div_of(k));
               since_rise[k] = 0;
               rx[k] = {rx[k][22:0], sda[k]};
               nbits[k]++;
            end
            if (!p_cs[k] && cs[k]) begin
               hi_cnt[k] = 1;
               if (qsize(k) == 0) begin
                  chk("unexpected_frame", {8'h0, rx[k]}, 32'hFFFF_FFFF);
               end else begin
                  exp_frame = (k == 0) ? expq0.pop_front() : expq1.pop_front();
                  chk("frame_data", {8'h0, rx[k]}, {8'h0, exp_frame});
                  chk("sck_rises", nbits[k], 24);
                  chk("cs_low_cycles", lo_cnt[k], 1 + 49 * div_of(k));
                  chk("frame_done_at_cs_rise", done[k], 1);
               end
            end
         end
         p_cs[k]  = cs[k];
         p_sck[k] = sck[k];
         p_sda[k] = sda[k];
      end
   end

   // ---------------- stimulus ----------------
   task automatic push(input int k, input logic [2:0] a, input logic [15:0] d, input logic [23:0] e);
      @(negedge clock);
      valid[k] = 1'b1;
      addr[k]  = a;
      data[k]  = d;
      last_stall = 0;
      while (!ready[k] && last_stall < 5000) begin
         @(negedge clock);
         last_stall++;
      end
      if (!ready[k]) begin
         chk("push_timeout", ready[k], 1);
         valid[k] = 1'b0;
      end else begin
         @(posedge clock);
         #1 valid[k] = 1'b0;
         if (k == 0) expq0.push_back(e);
         else        expq1.push_back(e);
         sent[k]++;
      end
   endtask

   task automatic drain(input int k);
      int n;
      n = 0;
      while ((busy[k] || qsize(k) != 0) && n < 20000) begin
         @(negedge clock);
         n++;
      end
      chk("drain_busy", busy[k], 0);
      chk("drain_queue", qsize(k), 0);
   endtask

   initial begin
      #400000;
      $display("FAIL global_timeout: simulation did not complete");
      $fatal(1, "timeout");
   end

   initial begin
      int n;
      rstn  = 2'b00;
      valid = 2'b00;
      addr  = '0;
      data  = '0;
      repeat (3) @(posedge clock);
      #1;
      for (int k = 0; k < 2; k++) begin
         chk("reset_cs", cs[k], 1);
         chk("reset_sck", sck[k], 0);
         chk("reset_sda", sda[k], 0);
         chk("reset_done", done[k], 0);
         chk("reset_busy", busy[k], 0);
         chk("reset_ready", ready[k], 1);
      end
      @(negedge clock);
      rstn = 2'b11;

      // single word
      push(0, 3'd2, 16'h1234, 24'h021234);
      chk("busy_after_accept", busy[0], 1);
      drain(0);

      // one frame in flight, then five back-to-back words against a 4-deep FIFO
      push(0, 3'd1, 16'h0001, 24'h010001);
      repeat (3) @(negedge clock);
      push(0, 3'd3, 16'hBEEF, 24'h03BEEF);
      push(0, 3'd4, 16'h00FF, 24'h0400FF);
      push(0, 3'd5, 16'hFF00, 24'h05FF00);
      push(0, 3'd6, 16'h8001, 24'h068001);
      chk("ready_low_when_full", ready[0], 0);
      push(0, 3'd2, 16'h7FFE, 24'h027FFE);
      chk("ready_stall_until_pop", 32'(last_stall >= 190 && last_stall <= 200), 1);
      drain(0);

      // every register address with the same data
      for (int a = 1; a <= 6; a++) begin
         push(0, 3'(a), 16'hA5C3, {5'b0, 3'(a), 16'hA5C3});
      end
      drain(0);

      // reset mid-frame after the 10th sck rise
      push(0, 3'd5, 16'hBEEF, 24'h05BEEF);
      n = 0;
      while (nbits[0] != 10 && n < 2000) begin
         @(posedge clock);
         n++;
      end
      chk("sck10_reached", nbits[0], 10);
      #1 rstn[0] = 1'b0;
      #1;
      chk("abort_cs", cs[0], 1);
      chk("abort_sck", sck[0], 0);
      chk("abort_done", done[0], 0);
      chk("abort_busy", busy[0], 0);
      chk("abort_ready", ready[0], 1);
      void'(expq0.pop_front());
      sent[0]--;
      repeat (3) @(negedge clock);
      rstn[0] = 1'b1;
      push(0, 3'd6, 16'h0013, 24'h060013);
      drain(0);

      // CLK_DIV=1 instance, including the pass-through addresses 0 and 7
      push(1, 3'd2, 16'h1234, 24'h021234);
      push(1, 3'd7, 16'hFFFF, 24'h07FFFF);
      push(1, 3'd0, 16'h8001, 24'h008001);
      drain(1);

      repeat (4) @(negedge clock);
      for (int k = 0; k < 2; k++) begin
         chk("sda_stable_while_sck_high", viol[k], 0);
         chk("frame_done_pulses", done_cnt[k], sent[k]);
      end

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule

`default_nettype wire
